// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
//
// Central pipeline controller for the 5-stage core. Decides, every cycle, how
// the PC and the IF/ID, ID/EX and EX/MEM pipeline registers advance. It stalls
// for data-memory wait, multi-cycle EX operations and load-use hazards, takes
// EX-resolved redirects, and selects the EX operand forwarding paths.
//
// The control outputs are combinational in the current state and inputs, so a
// stall condition takes effect in the same cycle it is seen. The FSM state and
// the performance counters are registered.
//
// Ports:
//   clk, rst_n                  core clock, asynchronous active-low reset
//   id_rs1/rs2_addr_i, _used_i  source registers of the instruction in ID
//   ex_rs1/rs2_addr_i           source registers of the instruction in EX
//   ex_rd_addr_i, ex_mem_read_i destination / load flag of the instruction in EX
//   ex_busy_i                   multi-cycle EX operation still running
//   ex_redirect_i               EX resolved a taken branch/jump
//   mem_rd_addr_i/_reg_write_i  EX/MEM destination and write flag
//   wb_rd_addr_i/_reg_write_i   MEM/WB destination and write flag
//   dmem_wait_i                 data memory not ready
//   pc_we_o, pc_sel_o           PC update enable, 0 = PC+4 / 1 = redirect
//   *_we_o, *_flush_o           pipeline register hold / bubble controls
//   fwd_a/b_sel_o               00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_cnt_o, flush_cnt_o    saturating stall / flush cycle counters
//   state_o                     FSM state (0 BOOT, 1 RUN, 2 EX_WAIT, 3 MEM_WAIT)
// -----------------------------------------------------------------------------
module hazard_ctrl_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic                      id_rs1_used_i,
    input  logic                      id_rs2_used_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
    input  logic                      ex_mem_read_i,
    input  logic                      ex_busy_i,
    input  logic                      ex_redirect_i,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr_i,
    input  logic                      mem_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_i,
    input  logic                      wb_reg_write_i,
    input  logic                      dmem_wait_i,
    output logic                      pc_we_o,
    output logic                      pc_sel_o,
    output logic                      if_id_we_o,
    output logic                      if_id_flush_o,
    output logic                      id_ex_we_o,
    output logic                      id_ex_flush_o,
    output logic                      ex_mem_we_o,
    output logic                      ex_mem_flush_o,
    output logic [1:0]                fwd_a_sel_o,
    output logic [1:0]                fwd_b_sel_o,
    output logic [CNT_WIDTH-1:0]      stall_cnt_o,
    output logic [CNT_WIDTH-1:0]      flush_cnt_o,
    output logic [1:0]                state_o
);

    localparam logic [1:0] ST_BOOT     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_EX_WAIT  = 2'd2;
    localparam logic [1:0] ST_MEM_WAIT = 2'd3;

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = {REG_ADDR_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]      CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]      CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        logic [CNT_WIDTH-1:0] result;
        if (&value) begin
            result = value;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

    // Forwarding source for one EX operand; the younger EX/MEM result wins.
    function automatic logic [1:0] fwd_select(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [REG_ADDR_WIDTH-1:0] mem_rd,
        input logic                      mem_wr,
        input logic [REG_ADDR_WIDTH-1:0] wb_rd,
        input logic                      wb_wr
    );
        logic [1:0] sel;
        if (mem_wr && (mem_rd != REG_ZERO) && (mem_rd == rs)) begin
            sel = 2'b01;
        end else if (wb_wr && (wb_rd != REG_ZERO) && (wb_rd == rs)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    logic [1:0]           state_r;
    logic [1:0]           state_next_s;
    logic [CNT_WIDTH-1:0] stall_cnt_r;
    logic [CNT_WIDTH-1:0] flush_cnt_r;

    logic load_use_s;
    logic redirect_take_s;
    logic stall_cycle_s;
    logic pc_we_s;
    logic pc_sel_s;
    logic if_id_we_s;
    logic if_id_flush_s;
    logic id_ex_we_s;
    logic id_ex_flush_s;
    logic ex_mem_we_s;
    logic ex_mem_flush_s;

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        load_use_s = ex_mem_read_i && (ex_rd_addr_i != REG_ZERO) &&
                     ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                      (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));
    end

    // Pipeline control decode and next-state selection. Once out of BOOT the
    // decision depends only on the inputs: a wait state that sees its wait
    // condition gone behaves exactly like RUN in that cycle, which is also
    // where a redirect held during the wait finally gets taken.
    always_comb begin
        pc_we_s         = 1'b1;
        pc_sel_s        = 1'b0;
        if_id_we_s      = 1'b1;
        if_id_flush_s   = 1'b0;
        id_ex_we_s      = 1'b1;
        id_ex_flush_s   = 1'b0;
        ex_mem_we_s     = 1'b1;
        ex_mem_flush_s  = 1'b0;
        redirect_take_s = 1'b0;
        state_next_s    = ST_RUN;
        case (state_r)
            ST_RUN, ST_EX_WAIT, ST_MEM_WAIT: begin
                if (dmem_wait_i) begin
                    pc_we_s      = 1'b0;
                    if_id_we_s   = 1'b0;
                    id_ex_we_s   = 1'b0;
                    ex_mem_we_s  = 1'b0;
                    state_next_s = ST_MEM_WAIT;
                end else if (ex_busy_i) begin
                    // EX holds its operation; MEM receives bubbles meanwhile.
                    pc_we_s        = 1'b0;
                    if_id_we_s     = 1'b0;
                    id_ex_we_s     = 1'b0;
                    ex_mem_flush_s = 1'b1;
                    state_next_s   = ST_EX_WAIT;
                end else if (ex_redirect_i) begin
                    // Redirect squashes the two younger instructions and
                    // therefore also resolves any load-use seen this cycle.
                    pc_sel_s        = 1'b1;
                    if_id_flush_s   = 1'b1;
                    id_ex_flush_s   = 1'b1;
                    redirect_take_s = 1'b1;
                    state_next_s    = ST_RUN;
                end else if (load_use_s) begin
                    pc_we_s       = 1'b0;
                    if_id_we_s    = 1'b0;
                    id_ex_flush_s = 1'b1;
                    state_next_s  = ST_RUN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                // BOOT: everything held and bubbled for one cycle.
                pc_we_s        = 1'b0;
                if_id_we_s     = 1'b0;
                id_ex_we_s     = 1'b0;
                ex_mem_we_s    = 1'b0;
                if_id_flush_s  = 1'b1;
                id_ex_flush_s  = 1'b1;
                ex_mem_flush_s = 1'b1;
                state_next_s   = ST_RUN;
            end
        endcase
    end

    // A stall cycle is any post-BOOT cycle in which the PC does not advance.
    always_comb begin
        stall_cycle_s = (state_r != ST_BOOT) && !pc_we_s;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Saturating stall and flush performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= CNT_ZERO;
            flush_cnt_r <= CNT_ZERO;
        end else begin
            if (stall_cycle_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (redirect_take_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign pc_we_o        = pc_we_s;
    assign pc_sel_o       = pc_sel_s;
    assign if_id_we_o     = if_id_we_s;
    assign if_id_flush_o  = if_id_flush_s;
    assign id_ex_we_o     = id_ex_we_s;
    assign id_ex_flush_o  = id_ex_flush_s;
    assign ex_mem_we_o    = ex_mem_we_s;
    assign ex_mem_flush_o = ex_mem_flush_s;
    assign fwd_a_sel_o    = fwd_select(ex_rs1_addr_i, mem_rd_addr_i, mem_reg_write_i,
                                       wb_rd_addr_i, wb_reg_write_i);
    assign fwd_b_sel_o    = fwd_select(ex_rs2_addr_i, mem_rd_addr_i, mem_reg_write_i,
                                       wb_rd_addr_i, wb_reg_write_i);
    assign stall_cnt_o    = stall_cnt_r;
    assign flush_cnt_o    = flush_cnt_r;
    assign state_o        = state_r;

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Central pipeline controller for the 5-stage core (IF → IF/ID → ID → ID/EX → EX → EX/MEM → MEM → WB).
- Generates PC write enable, per-pipeline-register write-enable and flush, PC redirect select and EX operand forwarding selects.
- Sequences stalls for load-use, multi-cycle EX ops and data-memory wait, and counts stall and flush cycles.

Parameters:
REG_ADDR_WIDTH, 5, register index width
CNT_WIDTH, 32, width of saturating performance counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_rs1_addr_i / id_rs2_addr_i  in  REG_ADDR_WIDTH  source regs of instr in ID
id_rs1_used_i / id_rs2_used_i  in  1  ID instr reads rs1/rs2
ex_rs1_addr_i / ex_rs2_addr_i  in  REG_ADDR_WIDTH  source regs of instr in EX
ex_rd_addr_i  in  REG_ADDR_WIDTH  dest of instr in EX
ex_mem_read_i  in  1  EX instr is a load
ex_busy_i  in  1  multi-cycle EX op not finished
ex_redirect_i  in  1  EX resolved taken branch/jump
mem_rd_addr_i / mem_reg_write_i  in  REG_ADDR_WIDTH / 1  EX/MEM dest, write flag
wb_rd_addr_i / wb_reg_write_i  in  REG_ADDR_WIDTH / 1  MEM/WB dest, write flag
dmem_wait_i  in  1  data memory not ready
pc_we_o  out  1  PC update enable
pc_sel_o  out  1  0 = PC+4, 1 = redirect target
if_id_we_o / if_id_flush_o  out  1 / 1  IF/ID hold / bubble
id_ex_we_o / id_ex_flush_o  out  1 / 1  ID/EX hold / bubble
ex_mem_we_o / ex_mem_flush_o  out  1 / 1  EX/MEM hold / bubble
fwd_a_sel_o / fwd_b_sel_o  out  2 / 2  00 regfile, 01 EX/MEM, 10 MEM/WB
stall_cnt_o / flush_cnt_o  out  CNT_WIDTH  saturating counters
state_o  out  2  FSM state

Behaviour:
- FSM states: BOOT=0, RUN=1, EX_WAIT=2, MEM_WAIT=3. Async reset → BOOT; counters → 0.
- BOOT, held exactly 1 cycle after reset release:
  - pc_we=0; all *_we=0; all *_flush=1; pc_sel=0.
  - Next state RUN.
- Output reset values while rst_n=0 are the BOOT values.
- Priority within RUN, highest first: dmem_wait > ex_busy > ex_redirect > load-use > none.
- dmem_wait_i=1 (any state except BOOT):
  - Go to, or stay in, MEM_WAIT.
  - pc_we, if_id_we, id_ex_we, ex_mem_we all 0; no flush.
  - MEM_WAIT → RUN in the cycle dmem_wait_i samples 0; outputs in that cycle follow RUN rules.
- ex_busy_i=1 and no dmem_wait:
  - EX_WAIT; pc_we, if_id_we, id_ex_we = 0.
  - ex_mem_we=1 with ex_mem_flush=1 (bubble into MEM).
  - Exit as for MEM_WAIT.
- ex_redirect_i in RUN:
  - pc_sel=1, pc_we=1.
  - if_id_flush=1, id_ex_flush=1; ex_mem_we=1; flush_cnt += 1.
- A redirect coincident with any wait is deferred. EX inputs are frozen, so the redirect is still asserted when the wait ends and is taken then, exactly once.
- Load-use hazard:
  - Condition: ex_mem_read_i, ex_rd_addr_i≠0, and (id_rs1_used_i && id_rs1_addr_i==ex_rd_addr_i || same for rs2).
  - Response: pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1. Exactly 1 cycle; the bubble clears the condition.
  - Redirect in the same cycle wins; no stall.
- No hazard: all we=1, all flush=0, pc_sel=0.
- Flush wins over we when both are asserted for the same register.
- Forwarding (combinational, independent of state), per operand:
  - 01 if mem_reg_write_i && mem_rd≠0 && mem_rd==ex_rsX.
  - Else 10 if wb_reg_write_i && wb_rd≠0 && wb_rd==ex_rsX.
  - Else 00.
  - EX/MEM has priority over MEM/WB.
- stall_cnt_o increments on every cycle with pc_we=0 outside BOOT.
- Both counters saturate at all-ones and never wrap.
- Reset asserted mid-stall → immediate BOOT; counters cleared.

Test Plan:
- Reset release: cycle 0 after release state_o=0, all flush=1, pc_we=0; cycle 1 state_o=1, all we=1, flush=0.
- Load-use: ex_mem_read_i=1, ex_rd=5, id_rs2=5 used → one cycle pc_we=0, if_id_we=0, id_ex_flush=1; stall_cnt_o 0→1. Repeat with ex_rd=0 → no stall.
- Redirect: ex_redirect_i=1 in RUN → pc_sel=1, if_id_flush=id_ex_flush=1, flush_cnt_o=1. Same cycle as load-use → no stall.
- dmem_wait_i high 3 cycles with ex_redirect_i held → state_o=3 for 3 cycles, all we=0, stall_cnt_o=3; redirect taken once on the 4th cycle, flush_cnt_o=1.
- ex_busy_i 4 cycles → state_o=2, ex_mem_flush=1 each cycle, then RUN. Add dmem_wait_i in cycle 2 → state_o=3 until dmem_wait drops.
- Forwarding: mem_rd=wb_rd=7, both writing, ex_rs1=7 → fwd_a=01; clear mem_reg_write → 10; rd=0 → 00.
- Counter saturation with CNT_WIDTH=4: 20 stall cycles → stall_cnt_o=15.
